// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix fetch/compute slice.
package matrix_pkg;

   localparam int unsigned NUM_ROWS  = 8;
   localparam int unsigned ROW_W     = 64;
   localparam int unsigned ELEM_W    = 8;
   localparam int unsigned ROW_IDX_W = $clog2(NUM_ROWS);

   typedef logic [ROW_IDX_W-1:0] row_idx_t;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWaitData,
      StDrain
   } fetch_state_e;

endpackage

// File: rtl/row_fifo.sv
// Small synchronous FIFO holding {row_idx, data} entries; head is read combinationally.
module row_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 67,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [CNT_W-1:0] count,
   output logic             empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
   endfunction

   assign empty     = (count_q == '0);
   assign do_pop    = pop && !empty;
   // A pop frees the slot being written, so a full FIFO still takes a same-cycle push.
   assign do_push   = push && ((count_q != FULL_CNT) || do_pop);
   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= next_ptr(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_q <= next_ptr(rd_ptr_q);
         end
         count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/matrix_row_fetcher.sv
// Avalon-MM read master fetching NUM_ROWS matrix rows into a valid/ready stream.
// Optional FETCH_TIMEOUT_EN adds a WAIT_DATA watchdog and a sticky err output.
module matrix_row_fetcher #(
   parameter int unsigned       NUM_ROWS   = matrix_pkg::NUM_ROWS,
   parameter int unsigned       DATA_W     = matrix_pkg::ROW_W,
   parameter int unsigned       ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
`ifdef FETCH_TIMEOUT_EN
   parameter int unsigned       TIMEOUT_CYCLES = 64,
`endif
   parameter int unsigned       FIFO_DEPTH = 2,
   localparam int unsigned      ROW_IDX_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
`ifdef FETCH_TIMEOUT_EN
   output logic                 err,
`endif
   output logic [ADDR_W-1:0]    avm_address,
   output logic                 avm_read,
   input  logic [DATA_W-1:0]    avm_readdata,
   input  logic                 avm_readdatavalid,
   input  logic                 avm_waitrequest,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    out_data,
   output logic [ROW_IDX_W-1:0] out_row,
   output logic                 out_last
);

   import matrix_pkg::*;

   localparam int unsigned ISSUE_W = $clog2(NUM_ROWS) + 1;
   localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned ENTRY_W = ROW_IDX_W + DATA_W;
   localparam logic [ISSUE_W-1:0]   ALL_ROWS  = ISSUE_W'(NUM_ROWS);
   localparam logic [ISSUE_W-1:0]   LAST_POP  = ISSUE_W'(NUM_ROWS - 1);
   localparam logic [ROW_IDX_W-1:0] LAST_ROW  = ROW_IDX_W'(NUM_ROWS - 1);
   localparam logic [CNT_W:0]       DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

   fetch_state_e         state_q, state_d;
   logic [ISSUE_W-1:0]   issue_row_q, issue_row_d;
   logic [ISSUE_W-1:0]   pop_cnt_q, pop_cnt_d;
   logic                 outstanding_q, outstanding_d;
   logic                 done_q, done_d;

   logic [CNT_W-1:0]     fifo_count;
   logic                 fifo_empty;
   logic [ENTRY_W-1:0]   head;
   logic [ROW_IDX_W-1:0] push_row;
   logic                 credit_ok, accept, push, pop, last_pop, timeout, flush;

   // Credit covers both buffered rows and the one in flight, so a push never hits a full FIFO.
   assign credit_ok = ({1'b0, fifo_count} + (CNT_W + 1)'(outstanding_q)) < DEPTH_LIM;
   assign accept    = avm_read && !avm_waitrequest;
   assign push      = avm_readdatavalid && outstanding_q;
   assign pop       = out_valid && out_ready;
   assign last_pop  = pop && (pop_cnt_q == LAST_POP);
   assign push_row  = ROW_IDX_W'(issue_row_q - ISSUE_W'(1));
   assign flush     = timeout;

`ifdef FETCH_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] tmo_cnt_q, tmo_cnt_d;
   logic        err_q, err_d;

   assign timeout = (state_q == StWaitData) && !push && (tmo_cnt_q == TMO_LAST);

   always_comb begin
      tmo_cnt_d = '0;
      if (state_q == StWaitData && !push) begin
         tmo_cnt_d = tmo_cnt_q + 16'd1;
      end
      err_d = err_q;
      if (state_q == StIdle && start) begin
         err_d = 1'b0;
      end else if (timeout) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmo_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         err_q     <= err_d;
      end
   end

   assign err = err_q;
`else
   assign timeout = 1'b0;
`endif

   row_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_row_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .push      (push),
      .push_data ({push_row, avm_readdata}),
      .pop       (pop),
      .head_data (head),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      issue_row_d   = issue_row_q;
      pop_cnt_d     = pop ? pop_cnt_q + ISSUE_W'(1) : pop_cnt_q;
      outstanding_d = outstanding_q;
      done_d        = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d     = StIssue;
               issue_row_d = '0;
               pop_cnt_d   = '0;
            end
         end
         StIssue: begin
            if (accept) begin
               state_d       = StWaitData;
               outstanding_d = 1'b1;
               issue_row_d   = issue_row_q + ISSUE_W'(1);
            end
         end
         StWaitData: begin
            if (push) begin
               outstanding_d = 1'b0;
               state_d       = (issue_row_q < ALL_ROWS) ? StIssue : StDrain;
            end else if (timeout) begin
               outstanding_d = 1'b0;
               state_d       = StIdle;
            end
         end
         StDrain: begin
            if (last_pop) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         issue_row_q   <= '0;
         pop_cnt_q     <= '0;
         outstanding_q <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         issue_row_q   <= issue_row_d;
         pop_cnt_q     <= pop_cnt_d;
         outstanding_q <= outstanding_d;
         done_q        <= done_d;
      end
   end

   always_comb begin
      busy        = (state_q != StIdle);
      avm_read    = (state_q == StIssue) && credit_ok;
      avm_address = '0;
      if (avm_read) begin
         avm_address = BASE_ADDR + ADDR_W'(issue_row_q);
      end
      done        = done_q;
      out_valid   = !fifo_empty;
      out_data    = head[DATA_W-1:0];
      out_row     = head[ENTRY_W-1:DATA_W];
      out_last    = out_valid && (out_row == LAST_ROW);
   end

endmodule

// File: tb/tb_matrix_row_fetcher.sv
// Directed bench for matrix_row_fetcher against a fixed-latency Avalon ROM model.
// Build with FETCH_TIMEOUT_EN to also exercise the watchdog.
module tb_matrix_row_fetcher;

   localparam int unsigned NumRows = 8;
   localparam logic [63:0] RowMul  = 64'h0101010101010101;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        busy;
   logic        done;
`ifdef FETCH_TIMEOUT_EN
   logic        err;
`endif
   logic [31:0] avm_address;
   logic        avm_read;
   logic [63:0] avm_readdata;
   logic        avm_readdatavalid;
   logic        avm_waitrequest;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic [2:0]  out_row;
   logic        out_last;

   matrix_row_fetcher dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .start             (start),
      .busy              (busy),
      .done              (done),
`ifdef FETCH_TIMEOUT_EN
      .err               (err),
`endif
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid),
      .avm_waitrequest   (avm_waitrequest),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_data          (out_data),
      .out_row           (out_row),
      .out_last          (out_last)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int tests = 0;
   int fails = 0;

   // Slave model knobs
   int stall_left = 0;
   bit mute       = 1'b0;
   bit inject     = 1'b0;

   // Monitor logs, sampled on the falling edge
   int          cyc = 0;
   int          done_cnt = 0;
   logic [31:0] acc_addr[$];
   int          acc_cyc[$];
   logic [31:0] stall_addr[$];
   int          rdv_cyc[$];
   logic [2:0]  pop_row[$];
   logic [63:0] pop_data[$];
   logic        pop_last[$];
   int          pop_cyc[$];

   // ROM slave: data returns 12 cycles after acceptance, row r = RowMul * r
   initial begin
      bit          pend = 1'b0;
      int          pend_cnt = 0;
      logic [31:0] pend_addr = '0;
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
      avm_readdata      = '0;
      forever begin
         @(posedge clk);
         #1;
         avm_readdatavalid = 1'b0;
         if (!reset_n) begin
            pend            = 1'b0;
            avm_waitrequest = 1'b0;
         end else begin
            if (pend) begin
               pend_cnt--;
               if (pend_cnt == 0) begin
                  pend              = 1'b0;
                  avm_readdatavalid = 1'b1;
                  avm_readdata      = RowMul * 64'(pend_addr);
               end
            end
            if (inject) begin
               inject            = 1'b0;
               avm_readdatavalid = 1'b1;
               avm_readdata      = 64'hDEAD;
            end
            avm_waitrequest = avm_read && (stall_left > 0);
            if (avm_waitrequest) stall_left--;
            if (avm_read && !avm_waitrequest && !mute) begin
               pend      = 1'b1;
               pend_cnt  = 12;
               pend_addr = avm_address;
            end
         end
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (reset_n) begin
         if (avm_read && !avm_waitrequest) begin
            acc_addr.push_back(avm_address);
            acc_cyc.push_back(cyc);
         end
         if (avm_read && avm_waitrequest) stall_addr.push_back(avm_address);
         if (avm_readdatavalid) rdv_cyc.push_back(cyc);
         if (out_valid && out_ready) begin
            pop_row.push_back(out_row);
            pop_data.push_back(out_data);
            pop_last.push_back(out_last);
            pop_cyc.push_back(cyc);
         end
         if (done) done_cnt++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      acc_addr.delete();
      acc_cyc.delete();
      stall_addr.delete();
      rdv_cyc.delete();
      pop_row.delete();
      pop_data.delete();
      pop_last.delete();
      pop_cyc.delete();
      done_cnt = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   // Bounded wait; leaves the bench in the done cycle when done is seen
   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         tick(1);
         n++;
      end
      check({tag, "_done_seen"}, 64'(done), 64'd1);
   endtask

   task automatic check_rows(input string tag);
      check({tag, "_acc_n"}, 64'(acc_addr.size()), 64'(NumRows));
      check({tag, "_pop_n"}, 64'(pop_row.size()), 64'(NumRows));
      foreach (acc_addr[i]) check($sformatf("%s_addr%0d", tag, i), 64'(acc_addr[i]), 64'(i));
      foreach (pop_row[i]) begin
         check($sformatf("%s_row%0d", tag, i), 64'(pop_row[i]), 64'(i));
         check($sformatf("%s_data%0d", tag, i), pop_data[i], RowMul * 64'(i));
         check($sformatf("%s_last%0d", tag, i), 64'(pop_last[i]), 64'(i == NumRows - 1));
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_read"}, 64'(avm_read), 64'd0);
      check({tag, "_addr"}, 64'(avm_address), 64'd0);
      check({tag, "_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_data"}, out_data, 64'd0);
      check({tag, "_row"}, 64'(out_row), 64'd0);
      check({tag, "_last"}, 64'(out_last), 64'd0);
   endtask

   initial begin
      int n;
      reset_n   = 1'b0;
      start     = 1'b0;
      out_ready = 1'b0;
      tick(2);
      check_outputs_zero("reset");
      reset_n = 1'b1;
      tick(2);

      // Basic fetch with out_ready held high
      out_ready = 1'b1;
      clear_logs();
      pulse_start();
      check("basic_busy", 64'(busy), 64'd1);
      wait_done("basic", 300);
      check("basic_busy_in_done", 64'(busy), 64'd0);
      tick(1);
      check("basic_done_one_cycle", 64'(done), 64'd0);
      check("basic_done_cnt", 64'(done_cnt), 64'd1);
      check_rows("basic");
      check("basic_push_to_valid",
            (pop_cyc.size() > 0 && rdv_cyc.size() > 0) ? 64'(pop_cyc[0] - rdv_cyc[0]) : '1,
            64'd1);

      // Readdatavalid with nothing outstanding must not reach the FIFO
      clear_logs();
      inject = 1'b1;
      tick(3);
      check("unsol_valid", 64'(out_valid), 64'd0);
      check("unsol_busy", 64'(busy), 64'd0);

      // Backpressure: two rows fill the buffer, then issue stops
      clear_logs();
      out_ready = 1'b0;
      pulse_start();
      tick(80);
      check("bp_acc_n", 64'(acc_addr.size()), 64'd2);
      check("bp_read_low", 64'(avm_read), 64'd0);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_head_row", 64'(out_row), 64'd0);
      tick(5);
      check("bp_hold_row", 64'(out_row), 64'd0);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_no_pop", 64'(pop_row.size()), 64'd0);
      out_ready = 1'b1;
      wait_done("bp", 300);
      tick(1);
      check("bp_done_cnt", 64'(done_cnt), 64'd1);
      check_rows("bp");

      // Waitrequest held for 5 cycles on the first read
      clear_logs();
      stall_left = 5;
      pulse_start();
      wait_done("stall", 300);
      tick(1);
      check("stall_cycles", 64'(stall_addr.size()), 64'd5);
      foreach (stall_addr[i]) check($sformatf("stall_addr%0d", i), 64'(stall_addr[i]), 64'd0);
      check_rows("stall");

      // Reset once row 3 has been pushed, then re-fetch from row 0
      clear_logs();
      pulse_start();
      n = 0;
      while (rdv_cyc.size() < 4 && n < 200) begin
         tick(1);
         n++;
      end
      check("rst_row3_pushed", 64'(rdv_cyc.size()), 64'd4);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_outputs_zero("midreset");
      tick(2);
      reset_n = 1'b1;
      tick(1);
      clear_logs();
      pulse_start();
      wait_done("restart", 300);
      tick(1);
      check("restart_done_cnt", 64'(done_cnt), 64'd1);
      check_rows("restart");

      // Start while busy is ignored; start in the done cycle begins a new fetch
      clear_logs();
      pulse_start();
      tick(20);
      pulse_start();
      wait_done("st1", 300);
      pulse_start();
      check("st_restart_busy", 64'(busy), 64'd1);
      check("st_first_acc_n", 64'(acc_addr.size()), 64'(NumRows));
      wait_done("st2", 300);
      tick(1);
      check("st_total_acc_n", 64'(acc_addr.size()), 64'(2 * NumRows));
      check("st_second_addr0", (acc_addr.size() > NumRows) ? 64'(acc_addr[NumRows]) : '1, 64'd0);
      check("st_done_cnt", 64'(done_cnt), 64'd2);

`ifdef FETCH_TIMEOUT_EN
      // Slave never answers: err after 64 WAIT_DATA cycles, no done
      clear_logs();
      mute = 1'b1;
      pulse_start();
      n = 0;
      while (err !== 1'b1 && n < 200) begin
         tick(1);
         n++;
      end
      check("tmo_err", 64'(err), 64'd1);
      check("tmo_busy", 64'(busy), 64'd0);
      check("tmo_wait_cycles", (acc_cyc.size() > 0) ? 64'(cyc - acc_cyc[0]) : '1, 64'd64);
      tick(2);
      check("tmo_no_done", 64'(done_cnt), 64'd0);
      check("tmo_flushed", 64'(out_valid), 64'd0);
      mute = 1'b0;
      clear_logs();
      pulse_start();
      check("tmo_err_cleared", 64'(err), 64'd0);
      check("tmo_restart_busy", 64'(busy), 64'd1);
      wait_done("tmo_restart", 300);
      tick(1);
      check_rows("tmo_restart");
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
